// File: rtl/mat_mult_pkg.sv
// Shared types and packing helpers for the sequential N x N matrix multiplier.
// Matrices travel as row-major, MSB-first flattened buses.
package mat_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COMP = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int calcRw(input int n, input int dw);
      return 2 * dw + $clog2(n);
   endfunction

   function automatic int busWidth(input int n, input int w);
      return n * n * w;
   endfunction

   // Element (0,0) sits in the top w bits, so the LSB index counts down from the top.
   function automatic int elemLsb(input int r, input int c, input int w, input int n);
      return (n * n - 1 - (r * n + c)) * w;
   endfunction

endpackage

// File: rtl/mat_mult_mac_lane.sv
// One MAC lane: a single DW x DW multiplier feeding an RW-bit accumulator.
// o_sum is the running total including the current product.
module mac_lane #(
   parameter int DW     = 8,
   parameter int RW     = 18,
   parameter int SIGNED = 0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_clear,
   input  logic          i_en,
   input  logic [DW-1:0] i_a,
   input  logic [DW-1:0] i_b,
   output logic [RW-1:0] o_sum
);

   logic [RW-1:0] r_accum;
   logic [RW-1:0] w_prodExt;

   // Operands are widened to 2*DW before multiplying so the product is exact.
   if (SIGNED != 0) begin : g_signed
      logic signed [2*DW-1:0] w_aS;
      logic signed [2*DW-1:0] w_bS;
      logic signed [2*DW-1:0] w_prod;
      assign w_aS      = (2*DW)'($signed(i_a));
      assign w_bS      = (2*DW)'($signed(i_b));
      assign w_prod    = w_aS * w_bS;
      assign w_prodExt = RW'(w_prod);
   end else begin : g_unsigned
      logic [2*DW-1:0] w_aU;
      logic [2*DW-1:0] w_bU;
      logic [2*DW-1:0] w_prod;
      assign w_aU      = (2*DW)'(i_a);
      assign w_bU      = (2*DW)'(i_b);
      assign w_prod    = w_aU * w_bU;
      assign w_prodExt = RW'(w_prod);
   end

   assign o_sum = r_accum + w_prodExt;

   always_ff @(posedge clk) begin
      if (!reset_n || i_clear) begin
         r_accum <= '0;
      end else if (i_en) begin
         r_accum <= o_sum;
      end
   end

endmodule

// File: rtl/mat_mult_mac.sv
// Sequential N x N matrix multiplier, C = A*B or C = C_prev + A*B.
// N MAC lanes (one per output column) step through k and rows, one (row,k) per cycle.
module mat_mult_mac
   import mat_mult_pkg::*;
#(
   parameter int N      = 4,
   parameter int DW     = 8,
   parameter int SIGNED = 0,
   parameter int RW     = calcRw(N, DW)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic                        acc,
   input  logic                        abort,
   input  logic [busWidth(N, DW)-1:0]  A_mat,
   input  logic [busWidth(N, DW)-1:0]  B_mat,
   output logic                        busy,
   output logic                        done,
   output logic                        valid,
   output logic [busWidth(N, RW)-1:0]  result
);

   localparam int             KW   = $clog2(N);
   localparam logic [KW-1:0]  LAST = KW'(N - 1);

   state_t                      r_state;
   state_t                      w_nextState;
   logic [busWidth(N, DW)-1:0]  r_aMat;
   logic [busWidth(N, DW)-1:0]  r_bMat;
   logic                        r_acc;
   logic [KW-1:0]               r_row;
   logic [KW-1:0]               r_k;
   logic [RW-1:0]               r_work   [N][N];
   logic [RW-1:0]               r_result [N][N];
   logic                        r_done;
   logic                        r_valid;

   logic [DW-1:0]               w_aArr [N][N];
   logic [DW-1:0]               w_bArr [N][N];
   logic [RW-1:0]               w_sum  [N];
   logic                        w_lastK;
   logic                        w_lastStep;
   logic                        w_laneClear;
   logic                        w_laneEn;

   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         assign w_aArr[r][c] = r_aMat[elemLsb(r, c, DW, N) +: DW];
         assign w_bArr[r][c] = r_bMat[elemLsb(r, c, DW, N) +: DW];
         assign result[elemLsb(r, c, RW, N) +: RW] = r_result[r][c];
      end
   end

   assign w_lastK     = (r_k == LAST);
   assign w_lastStep  = w_lastK && (r_row == LAST);
   assign w_laneEn    = (r_state == COMP);
   assign w_laneClear = ((r_state == IDLE) && start) || ((r_state == COMP) && w_lastK);

   // Lane c forms column c of the current row: sum over k of A[row][k]*B[k][c].
   for (genvar c = 0; c < N; c++) begin : g_lane
      mac_lane #(
         .DW     (DW),
         .RW     (RW),
         .SIGNED (SIGNED)
      ) u_lane (
         .clk     (clk),
         .reset_n (reset_n),
         .i_clear (w_laneClear),
         .i_en    (w_laneEn),
         .i_a     (w_aArr[r_row][r_k]),
         .i_b     (w_bArr[r_k][c]),
         .o_sum   (w_sum[c])
      );
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (start) w_nextState = COMP;
         COMP: begin
            if (abort) begin
               w_nextState = IDLE;
            end else if (w_lastStep) begin
               w_nextState = DONE;
            end
         end
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Result stays frozen until DONE so accumulate mode adds onto the pre-job value.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_aMat  <= '0;
         r_bMat  <= '0;
         r_acc   <= 1'b0;
         r_row   <= '0;
         r_k     <= '0;
         r_done  <= 1'b0;
         r_valid <= 1'b0;
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               r_work[r][c]   <= '0;
               r_result[r][c] <= '0;
            end
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_aMat  <= A_mat;
                  r_bMat  <= B_mat;
                  r_acc   <= acc;
                  r_row   <= '0;
                  r_k     <= '0;
                  r_valid <= 1'b0;
               end
            end
            COMP: begin
               if (abort) begin
                  r_valid <= 1'b0;
               end else if (w_lastK) begin
                  for (int c = 0; c < N; c++) begin
                     r_work[r_row][c] <= w_sum[c] + (r_acc ? r_result[r_row][c] : '0);
                  end
                  r_k   <= '0;
                  r_row <= r_row + KW'(1);
               end else begin
                  r_k <= r_k + KW'(1);
               end
            end
            DONE: begin
               if (abort) begin
                  r_valid <= 1'b0;
               end else begin
                  r_result <= r_work;
                  r_done   <= 1'b1;
                  r_valid  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy  = (r_state != IDLE);
   assign done  = r_done;
   assign valid = r_valid;

endmodule

// File: tb/tb_mat_mult_mac.sv
// Directed bench for mat_mult_mac: an unsigned and a signed 4x4/8-bit instance
// share the same stimulus; expected matrices are hand-derived constants.
module tb_mat_mult_mac;

   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int RW   = 18;
   localparam int MW   = N * N * DW;
   localparam int RESW = N * N * RW;

   logic            clk     = 1'b0;
   logic            reset_n = 1'b0;
   logic            start   = 1'b0;
   logic            acc     = 1'b0;
   logic            abort   = 1'b0;
   logic [MW-1:0]   aMat    = '0;
   logic [MW-1:0]   bMat    = '0;
   logic            busyU, doneU, validU;
   logic            busyS, doneS, validS;
   logic [RESW-1:0] resultU, resultS;
   logic [RESW-1:0] prevU;
   int              assertCount = 0;
   int              failCount   = 0;
   int              lat;

   always #5 clk = ~clk;

   mat_mult_mac #(.N(N), .DW(DW), .SIGNED(0)) dutU (
      .clk(clk), .reset_n(reset_n), .start(start), .acc(acc), .abort(abort),
      .A_mat(aMat), .B_mat(bMat), .busy(busyU), .done(doneU), .valid(validU),
      .result(resultU)
   );

   mat_mult_mac #(.N(N), .DW(DW), .SIGNED(1)) dutS (
      .clk(clk), .reset_n(reset_n), .start(start), .acc(acc), .abort(abort),
      .A_mat(aMat), .B_mat(bMat), .busy(busyS), .done(doneS), .valid(validS),
      .result(resultS)
   );

   task automatic checkOutput(input string tag, input logic [RESW-1:0] obs,
                              input logic [RESW-1:0] exp);
      assertCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [MW-1:0] fillMat(input logic [DW-1:0] v);
      logic [MW-1:0] m = '0;
      for (int i = 0; i < N * N; i++) m = {m[MW-DW-1:0], v};
      return m;
   endfunction

   function automatic logic [MW-1:0] seqMat();
      logic [MW-1:0] m = '0;
      for (int i = 0; i < N * N; i++) m = {m[MW-DW-1:0], DW'(i + 1)};
      return m;
   endfunction

   function automatic logic [MW-1:0] identMat();
      logic [MW-1:0] m = '0;
      for (int i = 0; i < N * N; i++) m = {m[MW-DW-1:0], DW'((i / N) == (i % N) ? 1 : 0)};
      return m;
   endfunction

   function automatic logic [RESW-1:0] fillRes(input logic [RW-1:0] v);
      logic [RESW-1:0] m = '0;
      for (int i = 0; i < N * N; i++) m = {m[RESW-RW-1:0], v};
      return m;
   endfunction

   function automatic logic [RESW-1:0] seqRes();
      logic [RESW-1:0] m = '0;
      for (int i = 0; i < N * N; i++) m = {m[RESW-RW-1:0], RW'(i + 1)};
      return m;
   endfunction

   // Leaves the bench at the falling edge right after the accepting edge.
   task automatic applyStimulus(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                input logic accIn);
      @(negedge clk);
      aMat  = a;
      bMat  = b;
      acc   = accIn;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      acc   = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int startJ, output int latOut);
      int j = startJ;
      while (doneU !== 1'b1 && j < 60) begin
         @(negedge clk);
         j++;
      end
      latOut = j;
      checkOutput({tag, " latency"}, RESW'(j), RESW'(17));
   endtask

   task automatic watchNoDone(input string tag, input int cycles);
      int seen = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (doneU === 1'b1 || doneS === 1'b1) seen++;
      end
      checkOutput(tag, RESW'(seen), '0);
   endtask

   task automatic runJob(input string tag, input logic [MW-1:0] a, input logic [MW-1:0] b,
                         input logic accIn, input logic [RESW-1:0] held,
                         input logic [RESW-1:0] expU, input logic [RESW-1:0] expS);
      applyStimulus(a, b, accIn);
      checkOutput({tag, " busy in comp"}, RESW'(busyU), RESW'(1));
      checkOutput({tag, " valid in comp"}, RESW'(validU), '0);
      checkOutput({tag, " result held"}, resultU, held);
      waitDone(tag, 0, lat);
      checkOutput({tag, " done signed"}, RESW'(doneS), RESW'(1));
      checkOutput({tag, " valid"}, RESW'(validU), RESW'(1));
      checkOutput({tag, " busy after"}, RESW'(busyU), '0);
      checkOutput({tag, " result unsigned"}, resultU, expU);
      checkOutput({tag, " result signed"}, resultS, expS);
      @(negedge clk);
      checkOutput({tag, " done pulse ends"}, RESW'(doneU), '0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      checkOutput("reset busy", RESW'(busyU), '0);
      checkOutput("reset done", RESW'(doneU), '0);
      checkOutput("reset valid", RESW'(validU), '0);
      checkOutput("reset result", resultU, '0);
      checkOutput("reset result signed", resultS, '0);
      reset_n = 1'b1;

      runJob("identity", identMat(), seqMat(), 1'b0, '0, seqRes(), seqRes());
      runJob("max", fillMat(8'hFF), fillMat(8'hFF), 1'b0, seqRes(),
             fillRes(18'd260100), fillRes(18'd4));
      runJob("neg x neg", fillMat(8'h80), fillMat(8'h80), 1'b0, fillRes(18'd260100),
             fillRes(18'd65536), fillRes(18'd65536));
      runJob("neg x pos", fillMat(8'h80), fillMat(8'h7F), 1'b0, fillRes(18'd65536),
             fillRes(18'd65024), fillRes(18'd197120));
      runJob("ones", fillMat(8'h01), fillMat(8'h01), 1'b0, fillRes(18'd65024),
             fillRes(18'd4), fillRes(18'd4));
      runJob("ones acc", fillMat(8'h01), fillMat(8'h01), 1'b1, fillRes(18'd4),
             fillRes(18'd8), fillRes(18'd8));
      runJob("max base", fillMat(8'hFF), fillMat(8'hFF), 1'b0, fillRes(18'd8),
             fillRes(18'd260100), fillRes(18'd4));
      runJob("max acc wrap", fillMat(8'hFF), fillMat(8'hFF), 1'b1, fillRes(18'd260100),
             fillRes(18'd258056), fillRes(18'd8));

      // A second start at +5 with different operands must be ignored.
      applyStimulus(identMat(), seqMat(), 1'b0);
      repeat (4) @(negedge clk);
      aMat  = fillMat(8'h01);
      bMat  = fillMat(8'h01);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone("busy start", 5, lat);
      checkOutput("busy start result", resultU, seqRes());
      @(negedge clk);
      watchNoDone("busy start no extra job", 20);
      checkOutput("busy start idle", RESW'(busyU), '0);

      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("idle abort valid", RESW'(validU), RESW'(1));
      checkOutput("idle abort result", resultU, seqRes());

      prevU = resultU;
      applyStimulus(fillMat(8'hFF), fillMat(8'hFF), 1'b0);
      repeat (7) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort busy", RESW'(busyU), '0);
      checkOutput("abort valid", RESW'(validU), '0);
      checkOutput("abort result", resultU, prevU);
      watchNoDone("abort no done", 20);
      checkOutput("abort valid stays", RESW'(validU), '0);

      @(negedge clk);
      aMat  = fillMat(8'h01);
      bMat  = fillMat(8'h01);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      checkOutput("start beats abort", RESW'(busyU), RESW'(1));
      waitDone("start beats abort", 0, lat);
      checkOutput("start beats abort result", resultU, fillRes(18'd4));

      applyStimulus(fillMat(8'hFF), fillMat(8'hFF), 1'b0);
      repeat (7) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      checkOutput("mid reset busy", RESW'(busyU), '0);
      checkOutput("mid reset valid", RESW'(validU), '0);
      checkOutput("mid reset result", resultU, '0);
      reset_n = 1'b1;
      watchNoDone("mid reset no done", 20);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
